// File: rtl/weight_sched_pkg.sv
// Shared types for the weight router sequencing controller.
package weight_sched_pkg;

  localparam int CFG_ADDR_WIDTH = 8;
  localparam int CFG_PASS_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_WAIT_PE,
    ST_STREAM,
    ST_REUSE,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic [CFG_ADDR_WIDTH-1:0] start_addr;
    logic [CFG_ADDR_WIDTH-1:0] addr_offset;
    logic [CFG_ADDR_WIDTH-1:0] route_size;
    logic [CFG_PASS_WIDTH-1:0] num_pass;
  } cfg_t;

  // A pass count of zero still streams the kernel once.
  function automatic logic [CFG_PASS_WIDTH-1:0] clamp_pass(input logic [CFG_PASS_WIDTH-1:0] n);
    return (n == '0) ? CFG_PASS_WIDTH'(1) : n;
  endfunction

endpackage

// File: rtl/weight_sched.sv
// Weight router sequencer: clear, load, then stream the weight set num_pass
// times with a FIFO rewind between passes. All outputs are registered.
module weight_sched
  import weight_sched_pkg::*;
#(
  parameter int ADDR_WIDTH = CFG_ADDR_WIDTH,
  parameter int PASS_WIDTH = CFG_PASS_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [ADDR_WIDTH-1:0] i_start_addr,
  input  logic [ADDR_WIDTH-1:0] i_addr_offset,
  input  logic [ADDR_WIDTH-1:0] i_route_size,
  input  logic [PASS_WIDTH-1:0] i_num_pass,
  input  logic                  i_pe_ready,
  input  logic                  i_rtr_ready,
  input  logic                  i_rtr_done,
  output logic                  o_rtr_reg_clear,
  output logic                  o_rtr_fifo_clear,
  output logic                  o_rtr_en,
  output logic                  o_rtr_pop_en,
  output logic                  o_rtr_reuse_en,
  output logic [ADDR_WIDTH-1:0] o_rtr_start_addr,
  output logic [ADDR_WIDTH-1:0] o_rtr_addr_offset,
  output logic [ADDR_WIDTH-1:0] o_rtr_route_size,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [PASS_WIDTH-1:0] o_pass_cnt
);

  state_t                state;
  cfg_t                  cfg;
  logic                  clear_q;
  logic                  load_first;
  logic [PASS_WIDTH-1:0] next_cnt;

  assign next_cnt          = o_pass_cnt + 1'b1;
  assign o_rtr_reg_clear   = clear_q;
  assign o_rtr_fifo_clear  = clear_q;
  assign o_rtr_start_addr  = ADDR_WIDTH'(cfg.start_addr);
  assign o_rtr_addr_offset = ADDR_WIDTH'(cfg.addr_offset);
  assign o_rtr_route_size  = ADDR_WIDTH'(cfg.route_size);

  // Strobes are set on the transition into the state that owns them, so each
  // output is a flop that mirrors the state register one-to-one.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state          <= ST_IDLE;
      cfg            <= '0;
      clear_q        <= 1'b0;
      load_first     <= 1'b0;
      o_rtr_en       <= 1'b0;
      o_rtr_pop_en   <= 1'b0;
      o_rtr_reuse_en <= 1'b0;
      o_busy         <= 1'b0;
      o_done         <= 1'b0;
      o_pass_cnt     <= '0;
    end else begin
      clear_q        <= 1'b0;
      load_first     <= 1'b0;
      o_rtr_en       <= 1'b0;
      o_rtr_pop_en   <= 1'b0;
      o_rtr_reuse_en <= 1'b0;
      o_done         <= 1'b0;
      if (i_abort) begin
        state   <= ST_IDLE;
        clear_q <= 1'b1;
        o_busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (i_start) begin
              cfg.start_addr  <= CFG_ADDR_WIDTH'(i_start_addr);
              cfg.addr_offset <= CFG_ADDR_WIDTH'(i_addr_offset);
              cfg.route_size  <= CFG_ADDR_WIDTH'(i_route_size);
              cfg.num_pass    <= clamp_pass(CFG_PASS_WIDTH'(i_num_pass));
              o_pass_cnt      <= '0;
              clear_q         <= 1'b1;
              o_busy          <= 1'b1;
              state           <= ST_CLEAR;
            end
          end
          ST_CLEAR: begin
            o_rtr_en   <= 1'b1;
            load_first <= 1'b1;
            state      <= ST_LOAD;
          end
          // Router ready is still reporting the pre-clear load in the first cycle.
          ST_LOAD: begin
            if (!load_first && i_rtr_ready) begin
              state <= ST_WAIT_PE;
            end else begin
              o_rtr_en <= 1'b1;
            end
          end
          ST_WAIT_PE: begin
            if (i_pe_ready) begin
              o_rtr_pop_en <= 1'b1;
              state        <= ST_STREAM;
            end
          end
          ST_STREAM: begin
            if (i_rtr_done) begin
              o_pass_cnt <= next_cnt;
              if (next_cnt == PASS_WIDTH'(cfg.num_pass)) begin
                o_done <= 1'b1;
                state  <= ST_DONE;
              end else begin
                o_rtr_reuse_en <= 1'b1;
                state          <= ST_REUSE;
              end
            end else begin
              o_rtr_pop_en <= 1'b1;
            end
          end
          ST_REUSE: begin
            state <= ST_WAIT_PE;
          end
          ST_DONE: begin
            o_busy <= 1'b0;
            state  <= ST_IDLE;
          end
          default: begin
            o_busy <= 1'b0;
            state  <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
